// File: rtl/seg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_pkg : seven-segment code constants and BCD-to-segment decode.
// Revision: 1.0
// ---------------------------------------------------------------------------
package seg_pkg;

  // Bit order {CA,CB,CC,CD,CE,CF,CG}, logic 1 = lit.
  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1110011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_div : free-running 0..DIV-1 counter, tick_o high while at DIV-1.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tick_div #(
  parameter int DIV = 2
) (
  input  logic fast_clk,
  input  logic rst,
  output logic tick_o
);

  localparam int              W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]    LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tick_o = (cnt_q == LAST);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_display : multiplexed 7-segment scanner with blink, DP, LZ blanking.
// Revision: 1.0
// ---------------------------------------------------------------------------
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                      fast_clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_en,
  input  logic                      blank_lz,
  input  logic                      enable,
  output logic [NUM_DIGITS-1:0]     anode_vec,
  output logic [6:0]                cathode_vec,
  output logic                      dp_out,
  output logic                      frame_done
);

  localparam int           IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic scan_tick;
  logic blink_tick;

  tick_div #(.DIV(SCAN_DIV)) u_scan_div (
    .fast_clk (fast_clk),
    .rst      (rst),
    .tick_o   (scan_tick)
  );

  tick_div #(.DIV(BLINK_DIV)) u_blink_div (
    .fast_clk (fast_clk),
    .rst      (rst),
    .tick_o   (blink_tick)
  );

  logic [IW-1:0]           idx_q, idx_d;
  logic                    phase_q, phase_d;
  logic                    load_pend_q, load_pend_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              cathode_q, cathode_d;
  logic                    dp_q, dp_d;

  logic                    frame_end;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   sel;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    cur_lz;
  logic                    dark;

  always_comb begin
    frame_end    = scan_tick && (idx_q == LAST_IDX);
    idx_d        = idx_q;
    if (scan_tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    phase_d      = phase_q ^ blink_tick;
    frame_done_d = frame_end;
    load_pend_d  = 1'b0;

    // Snapshot only at frame boundaries so a frame never mixes old and new data.
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_blink_d  = sh_blink_q;
    if (load_pend_q || frame_end) begin
      sh_digits_d = digits_in;
      sh_dp_d     = dp_in;
      sh_blink_d  = blink_en;
    end

    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above  = zero_above && (sh_digits_q[4*k +: 4] == 4'd0);
      lz_blank[k] = blank_lz && (k != 0) && zero_above;
    end

    sel       = '0;
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        sel[k]    = 1'b1;
        cur_nib   = sh_digits_q[4*k +: 4];
        cur_dp    = sh_dp_q[k];
        cur_blink = sh_blink_q[k];
        cur_lz    = lz_blank[k];
      end
    end

    dark      = !enable || (cur_blink && !phase_q) || cur_lz;
    anode_d   = (dark ? '0 : sel) ^ {NUM_DIGITS{ACTIVE_LOW}};
    cathode_d = (dark ? SEG_OFF : bcd_to_seg(cur_nib)) ^ {7{ACTIVE_LOW}};
    dp_d      = (!dark && cur_dp) ^ ACTIVE_LOW;
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      phase_q      <= 1'b1;
      load_pend_q  <= 1'b1;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_blink_q   <= '0;
      frame_done_q <= 1'b0;
      anode_q      <= {NUM_DIGITS{ACTIVE_LOW}};
      cathode_q    <= {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
    end else begin
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      load_pend_q  <= load_pend_d;
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_blink_q   <= sh_blink_d;
      frame_done_q <= frame_done_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      dp_q         <= dp_d;
    end
  end

  assign anode_vec   = anode_q;
  assign cathode_vec = cathode_q;
  assign dp_out      = dp_q;
  assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_scan_display : randomized check of both polarities against a cycle model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_seg_scan_display;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 16;
  localparam int FR = SD * N;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blink = 4'h0;
  logic        blz = 1'b0;
  logic        en = 1'b1;

  logic [3:0]  an0, an1;
  logic [6:0]  ca0, ca1;
  logic        dp0, dp1, fd0, fd1;
  logic [12:0] obs0, obs1;

  int          errors = 0;
  int          checks = 0;
  int          n = 0;
  logic [15:0] sh_dig;
  logic [3:0]  sh_dp, sh_bl;
  logic [12:0] exp0, exp1;
  logic [6:0]  seg_tab [16];

  assign obs0 = {an0, ca0, dp0, fd0};
  assign obs1 = {an1, ca1, dp1, fd1};

  always #5 clk = ~clk;

  seg_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD), .ACTIVE_LOW(1'b0)) dut (
    .fast_clk (clk), .rst (rst), .digits_in (digits), .dp_in (dp), .blink_en (blink),
    .blank_lz (blz), .enable (en), .anode_vec (an0), .cathode_vec (ca0), .dp_out (dp0),
    .frame_done (fd0)
  );

  seg_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1)) dut_al (
    .fast_clk (clk), .rst (rst), .digits_in (digits), .dp_in (dp), .blink_en (blink),
    .blank_lz (blz), .enable (en), .anode_vec (an1), .cathode_vec (ca1), .dp_out (dp1),
    .frame_done (fd1)
  );

  // Expected outputs follow from the edge count since reset: digit k owns SD cycles
  // per frame, the display trails by one edge, the blink phase flips every BD edges.
  task automatic model_edge();
    int idx;
    bit ph, dark, upper_zero;
    @(posedge clk);
    n++;
    idx        = ((n - 1) / SD) % N;
    ph         = (((n - 1) / BD) % 2) == 0;
    upper_zero = ((sh_dig >> (4 * idx)) == 16'd0);
    dark       = !en || (sh_bl[idx] && !ph) || (blz && idx > 0 && upper_zero);
    exp0       = dark ? 13'd0 : {4'(1 << idx), seg_tab[sh_dig[4*idx +: 4]], sh_dp[idx], 1'b0};
    exp0[0]    = (n % FR == 0);
    exp1       = {~exp0[12:1], exp0[0]};
    if (n == 1 || n % FR == 0) begin
      sh_dig = digits;
      sh_dp  = dp;
      sh_bl  = blink;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0; sh_dig = '0; sh_dp = '0; sh_bl = '0;
  endtask

  task automatic test_reset();
    digits = 16'h1234; dp = 4'h0; blink = 4'h0; blz = 1'b0; en = 1'b1;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (obs0 !== 13'd0 || obs1 !== {12'hFFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got %b/%b want %b/%b", obs0, obs1, 13'd0, {12'hFFF, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0; sh_dig = '0; sh_dp = '0; sh_bl = '0;
  endtask

  task automatic test_scan_order();
    int fd_cnt = 0;
    digits = 16'h1234; dp = 4'h0; blink = 4'h0; blz = 1'b0; en = 1'b1;
    do_reset();
    repeat (48) begin
      model_edge();
      fd_cnt += fd0;
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        errors++;
        $display("FAIL scan_order n=%0d got %b/%b want %b/%b", n, obs0, obs1, exp0, exp1);
      end
    end
    checks++;
    if (fd_cnt != 3) begin
      errors++;
      $display("FAIL frame_done_count got %0d want 3", fd_cnt);
    end
  endtask

  task automatic test_blink();
    blink = 4'b0011;
    repeat (96) begin
      model_edge();
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        errors++;
        $display("FAIL blink n=%0d got %b/%b want %b/%b", n, obs0, obs1, exp0, exp1);
      end
    end
    blink = 4'b0000;
  endtask

  task automatic test_lz_blank();
    blz = 1'b1;
    for (int p = 0; p < 2; p++) begin
      digits = (p == 0) ? 16'h0050 : 16'h0000;
      repeat (40) begin
        model_edge();
        checks++;
        if ({obs0, obs1} !== {exp0, exp1}) begin
          errors++;
          $display("FAIL lz_blank d=%h n=%0d got %b/%b want %b/%b", digits, n, obs0, obs1, exp0, exp1);
        end
      end
    end
    blz = 1'b0;
  endtask

  task automatic test_coherency();
    int guard = 0;
    digits = 16'h1234; dp = 4'h0; blink = 4'h0; blz = 1'b0; en = 1'b1;
    do_reset();
    while ((n < FR + 1 || ((n - 1) / SD) % N != 1) && guard < 200) begin
      model_edge();
      guard++;
    end
    digits = 16'h5678;
    while (((n - 1) / SD) % N != 2 && guard < 200) begin
      model_edge();
      guard++;
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        errors++;
        $display("FAIL coherency n=%0d got %b/%b want %b/%b", n, obs0, obs1, exp0, exp1);
      end
    end
    checks++;
    if (guard >= 200 || an0 !== 4'b0100 || ca0 !== 7'b1101101) begin
      errors++;
      $display("FAIL coherency_old_digit2 got an=%b ca=%b want an=0100 ca=1101101", an0, ca0);
    end
    repeat (24) begin
      model_edge();
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        errors++;
        $display("FAIL coherency_after n=%0d got %b/%b want %b/%b", n, obs0, obs1, exp0, exp1);
      end
    end
  endtask

  task automatic test_polarity();
    digits = 16'h000A; dp = 4'b0001; blz = 1'b0; blink = 4'h0; en = 1'b1;
    do_reset();
    model_edge();
    model_edge();
    checks++;
    if (an1 !== 4'b1110 || ca1 !== 7'b1111110 || dp1 !== 1'b0) begin
      errors++;
      $display("FAIL polarity_dash got an=%b ca=%b dp=%b want an=1110 ca=1111110 dp=0", an1, ca1, dp1);
    end
    repeat (30) begin
      model_edge();
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        errors++;
        $display("FAIL polarity n=%0d got %b/%b want %b/%b", n, obs0, obs1, exp0, exp1);
      end
    end
    dp = 4'h0;
  endtask

  task automatic test_random();
    repeat (400) begin
      model_edge();
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        errors++;
        $display("FAIL random n=%0d got %b/%b want %b/%b", n, obs0, obs1, exp0, exp1);
      end
      digits = 16'($urandom());
      if ($urandom_range(0, 2) == 0) digits[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) digits[7:4] = 4'h0;
      dp    = 4'($urandom());
      blink = 4'($urandom());
      blz   = 1'($urandom());
      en    = ($urandom_range(0, 9) != 0);
    end
    blink = 4'h0; en = 1'b1; blz = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    digits = 16'h1234; dp = 4'h0;
    while (((n - 1) / SD) % N != 2 && guard < 50) begin
      model_edge();
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (guard >= 50 || obs0 !== 13'd0 || obs1 !== {12'hFFF, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_off got %b/%b want %b/%b", obs0, obs1, 13'd0, {12'hFFF, 1'b0});
    end
    #1 rst = 1'b0;
    n = 0; sh_dig = '0; sh_dp = '0; sh_bl = '0;
    repeat (20) begin
      model_edge();
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        errors++;
        $display("FAIL async_restart n=%0d got %b/%b want %b/%b", n, obs0, obs1, exp0, exp1);
      end
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000; seg_tab[2]  = 7'b1101101;
    seg_tab[3]  = 7'b1111001; seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
    seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000; seg_tab[8]  = 7'b1111111;
    seg_tab[9]  = 7'b1110011;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000001;
    sh_dig = '0; sh_dp = '0; sh_bl = '0;

    test_reset();
    test_scan_order();
    test_blink();
    test_lz_blank();
    test_coherency();
    test_polarity();
    test_random();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
